// File: rtl/core_pkg.sv
// Definitions shared across the core front end.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Wide enough for the live window plus responses still owed after a redirect.
    localparam int OUTSTANDING_W = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: a circular FIFO of {pc, instr} entries.
// It supports simultaneous push and pop, and a flush that empties it in one cycle.
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit. It issues requests under a credit limit and tracks in-order responses.
// It also buffers instructions for decode and discards stale responses after a redirect.
module fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int FCNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IPTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [IPTR_W-1:0]        ILAST      = IPTR_W'(BUF_DEPTH - 1);
    localparam logic [OUTSTANDING_W-1:0] CREDITS    = OUTSTANDING_W'(BUF_DEPTH);
    localparam logic [XLEN-1:0]          ALIGN_MASK = 32'hFFFF_FFFC;

    logic [XLEN-1:0]          pc;
    logic [OUTSTANDING_W-1:0] outstanding;
    logic [OUTSTANDING_W-1:0] drop_count;
    logic [OUTSTANDING_W-1:0] live_used;
    logic                     req_fire;
    logic                     rsp_drop;
    logic                     rsp_keep;

    logic [XLEN-1:0]          inflight_addr [BUF_DEPTH];
    logic [IPTR_W-1:0]        if_wr_ptr;
    logic [IPTR_W-1:0]        if_rd_ptr;

    fetch_entry_t             buf_push_data;
    fetch_entry_t             buf_head;
    logic                     buf_empty;
    logic [FCNT_W-1:0]        buf_count;

    function automatic logic [IPTR_W-1:0] iptr_inc(input logic [IPTR_W-1:0] p);
        return (p == ILAST) ? '0 : p + IPTR_W'(1);
    endfunction

    // Responses still owed to a dropped stream do not hold buffer credit.
    assign live_used = outstanding - drop_count + OUTSTANDING_W'(buf_count);

    // The outstanding cap only matters if a memory withholds responses across many redirects.
    assign imem_req_valid = rst_n && !redirect_valid && (live_used < CREDITS)
                            && (outstanding != '1);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = redirect_valid || (drop_count != '0);
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= outstanding + OUTSTANDING_W'(req_fire)
                                       - OUTSTANDING_W'(imem_rsp_valid);
            if (redirect_valid) begin
                drop_count <= outstanding - OUTSTANDING_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop_count != '0)) begin
                drop_count <= drop_count - OUTSTANDING_W'(1);
            end
        end
    end

    // The in-flight queue holds only addresses whose responses will be kept.
    // Entries owed to a dropped stream are covered by drop_count instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_wr_ptr <= '0;
            if_rd_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                inflight_addr[i] <= '0;
            end
        end else if (redirect_valid) begin
            if_wr_ptr <= '0;
            if_rd_ptr <= '0;
        end else begin
            if (req_fire) begin
                inflight_addr[if_wr_ptr] <= pc;
                if_wr_ptr                <= iptr_inc(if_wr_ptr);
            end
            if (rsp_keep) begin
                if_rd_ptr <= iptr_inc(if_rd_ptr);
            end
        end
    end

    assign buf_push_data = '{pc: inflight_addr[if_rd_ptr], instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (buf_push_data),
        .pop       (inst_ready),
        .flush     (redirect_valid),
        .head      (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign inst_valid = !buf_empty;
    assign inst_data  = buf_empty ? '0 : buf_head.instr;
    assign inst_pc    = buf_empty ? '0 : buf_head.pc;

    rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch. A memory and reference model driven by queues predict every output each cycle.
module tb_fetch;
    import core_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: every issued-but-unanswered address, how many are stale, and the buffer.
    logic [31:0] m_pc;
    logic [31:0] m_inflight[$];
    int          m_drop;
    logic [31:0] m_buf_pc[$];
    logic [31:0] m_buf_data[$];

    logic [31:0] fire_log[$];
    logic [31:0] inst_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000;
        m_inflight.delete();
        m_drop = 0;
        m_buf_pc.delete();
        m_buf_data.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0000_0000);
        chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        chk({tag, "_inst_pc"}, inst_pc, 32'd0);
        chk({tag, "_inst_data"}, inst_data, 32'd0);
    endtask

    task automatic step(input bit rdy, input int rpct, input bit iready,
                        input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          exp_rv;
        logic [31:0] a;
        @(negedge clk);
        imem_req_ready = rdy;
        inst_ready     = iready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = (m_inflight.size() > 0) && ($urandom_range(99) < rpct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(m_inflight[0]) : $urandom;
        #1;
        exp_rv = !redir && ((m_inflight.size() - m_drop + m_buf_pc.size()) < DEPTH);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_buf_pc.size() > 0});
        chk("inst_pc", inst_pc, (m_buf_pc.size() > 0) ? m_buf_pc[0] : 32'd0);
        chk("inst_data", inst_data, (m_buf_pc.size() > 0) ? m_buf_data[0] : 32'd0);
        if (imem_req_valid && rdy) fire_log.push_back(imem_req_addr);
        if (inst_valid && iready && !redir) inst_log.push_back(inst_pc);

        if (redir) begin
            if (rsp) void'(m_inflight.pop_front());
            m_drop = m_inflight.size();
            m_buf_pc.delete();
            m_buf_data.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (iready && m_buf_pc.size() > 0) begin
                void'(m_buf_pc.pop_front());
                void'(m_buf_data.pop_front());
            end
            if (rsp) begin
                a = m_inflight.pop_front();
                if (m_drop > 0) m_drop--;
                else begin
                    m_buf_pc.push_back(a);
                    m_buf_data.push_back(mem_word(a));
                end
            end
            if (exp_rv && rdy) begin
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (m_inflight.size() > 0 || m_buf_pc.size() > 0); i++)
            step(1'b0, 100, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(99) < 75, 60, $urandom_range(99) < 70,
                 $urandom_range(99) < 3, $urandom);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk_reset_outputs({tag, "_now"});
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs({tag, "_held"});
        rst_n = 1'b1;
        #1;
        chk({tag, "_first_req_valid"}, {31'b0, imem_req_valid}, 32'd1);
        chk({tag, "_first_req_addr"}, imem_req_addr, 32'h0000_0000);
    endtask

    initial begin
        int base_f;
        int base_i;
        #1 rst_n = 1'b0;
        model_reset();
        reset_pulse("por");

        // 1-cycle memory, always ready.
        base_f = fire_log.size();
        base_i = inst_log.size();
        repeat (12) step(1'b1, 100, 1'b1, 1'b0, 32'd0);
        chk("seq_req0", fire_log[base_f], 32'h0);
        chk("seq_req1", fire_log[base_f + 1], 32'h4);
        chk("seq_req2", fire_log[base_f + 2], 32'h8);
        chk("seq_inst0", inst_log[base_i], 32'h0);
        chk("seq_inst1", inst_log[base_i + 1], 32'h4);
        chk("seq_inst2", inst_log[base_i + 2], 32'h8);

        // Decode stall: the credit limit caps the requests issued.
        drain();
        base_f = fire_log.size();
        base_i = inst_log.size();
        repeat (5) step(1'b1, 100, 1'b0, 1'b0, 32'd0);
        chk("stall_req_limit", {31'b0, (fire_log.size() - base_f) <= DEPTH}, 32'd1);
        drain();
        chk("stall_drain_cnt", inst_log.size() - base_i, fire_log.size() - base_f);
        chk("stall_drain_first", inst_log[base_i], fire_log[base_f]);

        // Redirect with two responses outstanding.
        drain();
        repeat (2) step(1'b1, 0, 1'b1, 1'b0, 32'd0);
        chk("redir_outstanding", m_inflight.size(), 32'd2);
        step(1'b1, 0, 1'b1, 1'b1, 32'h0000_0103);
        base_f = fire_log.size();
        base_i = inst_log.size();
        repeat (8) step(1'b1, 100, 1'b1, 1'b0, 32'd0);
        chk("redir_req_addr", fire_log[base_f], 32'h0000_0100);
        chk("redir_inst_pc", inst_log[base_i], 32'h0000_0100);

        // Redirect together with a response while the buffer holds an entry.
        drain();
        step(1'b1, 0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 100, 1'b0, 1'b0, 32'd0);
        step(1'b1, 100, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 0, 1'b1, 1'b0, 32'd0);
        chk("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
        base_i = inst_log.size();
        repeat (6) step(1'b1, 100, 1'b1, 1'b0, 32'd0);
        chk("flush_first_inst", inst_log[base_i], 32'h0000_0200);

        // Address wrap at the top of the space.
        drain();
        step(1'b0, 100, 1'b1, 1'b1, 32'hFFFF_FFFE);
        base_f = fire_log.size();
        repeat (6) step(1'b1, 100, 1'b1, 1'b0, 32'd0);
        chk("wrap_req0", fire_log[base_f], 32'hFFFF_FFFC);
        chk("wrap_req1", fire_log[base_f + 1], 32'h0000_0000);

        random_steps(1500);

        // Reset mid-stream with two requests outstanding.
        drain();
        repeat (2) step(1'b1, 0, 1'b1, 1'b0, 32'd0);
        reset_pulse("mid");
        base_i = inst_log.size();
        repeat (8) step(1'b1, 100, 1'b1, 1'b0, 32'd0);
        chk("mid_first_inst", inst_log[base_i], 32'h0000_0000);
        chk("mid_second_inst", inst_log[base_i + 1], 32'h0000_0004);

        random_steps(1500);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
